// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: counter sample stream in, lock/error status out.
// last_bad/last_exp exist only when COUNT_SEQ_CHECKER_LAST_BAD_EN is defined.
interface count_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 16
);
  logic in_valid;
  logic [WIDTH-1:0] count_in;
  logic err_clr;
  logic locked;
  logic err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
  logic [WIDTH-1:0] last_bad;
  logic [WIDTH-1:0] last_exp;
  modport master(
    output in_valid, count_in, err_clr,
    input locked, err_pulse, err_count, expected, last_bad, last_exp
  );
  modport slave(
    input in_valid, count_in, err_clr,
    output locked, err_pulse, err_count, expected, last_bad, last_exp
  );
`else
  modport master(
    output in_valid, count_in, err_clr,
    input locked, err_pulse, err_count, expected
  );
  modport slave(
    input in_valid, count_in, err_clr,
    output locked, err_pulse, err_count, expected
  );
`endif
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker: checks a +1 counter stream, locks after LOCK_N good steps, tallies breaks.
// COUNT_SEQ_CHECKER_LAST_BAD_EN adds last_bad/last_exp capture of the offending sample.
module count_seq_checker #(
  parameter int WIDTH = 8,
  parameter int LOCK_N = 4,
  parameter int ERR_W = 16
) (
  input logic clk,
  input logic rst,
  count_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRAIN, LOCKED} state_t;
  state_t state, state_nx;
  logic [7:0] run, run_nx;
  logic match, err;
  // expected always holds prev + 1, so it doubles as the previous-sample register
  assign match = bus.count_in == bus.expected;
  always_comb begin
    state_nx = state;
    run_nx = run;
    err = 1'b0;
    if (bus.in_valid)
      case (state)
        IDLE: begin
          state_nx = TRAIN;
          run_nx = '0;
        end
        TRAIN: begin
          run_nx = match ? run + 8'd1 : '0;
          state_nx = (match && run_nx == 8'(LOCK_N)) ? LOCKED : TRAIN;
        end
        LOCKED: begin
          err = !match;
          state_nx = match ? LOCKED : TRAIN;
          run_nx = match ? run : '0;
        end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run <= '0;
      bus.expected <= '0;
      bus.locked <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_count <= '0;
    end else begin
      state <= state_nx;
      run <= run_nx;
      bus.locked <= state_nx == LOCKED;
      bus.err_pulse <= err;
      if (bus.in_valid) bus.expected <= bus.count_in + WIDTH'(1);
      bus.err_count <= bus.err_clr ? '0
                     : (err && bus.err_count != '1) ? bus.err_count + ERR_W'(1)
                     : bus.err_count;
    end
  end
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.last_bad <= '0;
      bus.last_exp <= '0;
    end else if (err) begin
      bus.last_bad <= bus.count_in;
      bus.last_exp <= bus.expected;
    end
  end
`endif
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: scoreboard bench; a behavioural model queues expected outputs per driven cycle.
module tb_count_seq_checker;
  localparam int W = 8;
  localparam int LN = 4;
  localparam int EW = 2;
  typedef struct packed {
    logic locked;
    logic err_pulse;
    logic [EW-1:0] err_count;
    logic [W-1:0] expected;
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
    logic [W-1:0] last_bad;
    logic [W-1:0] last_exp;
`endif
  } out_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  out_t obs_q[$];
  out_t m = '0;
  int m_st = 0;
  int m_run = 0;
  logic [W-1:0] m_prev = '0;
  always #5 clk = ~clk;
  count_seq_checker_if #(.WIDTH(W), .ERR_W(EW)) bus();
  count_seq_checker #(.WIDTH(W), .LOCK_N(LN), .ERR_W(EW)) dut(.clk(clk), .rst(rst), .bus(bus));

  function automatic out_t sample();
    out_t s;
    s.locked = bus.locked;
    s.err_pulse = bus.err_pulse;
    s.err_count = bus.err_count;
    s.expected = bus.expected;
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
    s.last_bad = bus.last_bad;
    s.last_exp = bus.last_exp;
`endif
    return s;
  endfunction

  task automatic step(input logic r, input logic v, input logic [W-1:0] c, input logic clr);
    logic [W-1:0] nx;
    rst = r;
    bus.in_valid = v;
    bus.count_in = c;
    bus.err_clr = clr;
    if (r) begin
      m = '0;
      m_st = 0;
      m_run = 0;
      m_prev = '0;
    end else begin
      m.err_pulse = 1'b0;
      if (v) begin
        nx = m_prev + W'(1);
        if (m_st == 0) begin
          m_st = 1;
          m_run = 0;
        end else if (c == nx) begin
          if (m_st == 1) begin
            m_run++;
            if (m_run == LN) m_st = 2;
          end
        end else begin
          if (m_st == 2) begin
            m.err_pulse = 1'b1;
            if (m.err_count != '1) m.err_count = m.err_count + EW'(1);
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
            m.last_bad = c;
            m.last_exp = nx;
`endif
          end
          m_st = 1;
          m_run = 0;
        end
        m_prev = c;
        m.expected = c + W'(1);
      end
      if (clr) m.err_count = '0;
      m.locked = m_st == 2;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    obs_q.push_back(sample());
  endtask

  task automatic test_reset();
    out_t o, e;
    step(1'b1, 1'b1, 8'h33, 1'b1);
    checks++;
    if (sample() !== out_t'(0)) begin errors++; $display("FAIL reset_zero got %h want 0", sample()); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_lock();
    out_t o, e;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'(10 + i), 1'b0);
      if (i == 3) begin
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", bus.locked); end
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_set got %b want 1", bus.locked); end
    checks++;
    if (bus.expected !== 8'd15) begin errors++; $display("FAIL lock_expected got %0d want 15", bus.expected); end
    checks++;
    if (bus.err_count !== 2'd0) begin errors++; $display("FAIL lock_errcnt got %0d want 0", bus.err_count); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lock_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_wrap();
    out_t o, e;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'(250 + i), 1'b0);
      checks++;
      if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse[%0d] got %b want 0", i, bus.err_pulse); end
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.expected !== 8'd2) begin
      errors++; $display("FAIL wrap_end got locked=%b exp=%0d want locked=1 exp=2", bus.locked, bus.expected);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_error_relock();
    out_t o, e;
    logic [7:0] seq [11] = '{8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd30, 8'd31, 8'd32, 8'd33, 8'd34};
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, seq[i], 1'b0);
      if (i == 6) begin
        checks++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 2'd1 || bus.locked !== 1'b0) begin
          errors++;
          $display("FAIL err_hit got pulse=%b cnt=%0d locked=%b want 1 1 0", bus.err_pulse, bus.err_count, bus.locked);
        end
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
        checks++;
        if (bus.last_bad !== 8'd30 || bus.last_exp !== 8'd22) begin
          errors++; $display("FAIL err_capture got bad=%0d exp=%0d want 30 22", bus.last_bad, bus.last_exp);
        end
`endif
      end
      if (i == 7) begin
        checks++;
        if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", bus.err_pulse); end
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL err_relock got %b want 1", bus.locked); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL err_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_stall();
    out_t o, e;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (bus.expected !== 8'd6 || bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got exp=%0d locked=%b pulse=%b want 6 1 0", bus.expected, bus.locked, bus.err_pulse);
      end
    end
    step(1'b0, 1'b1, 8'd6, 1'b0);
    checks++;
    if (bus.expected !== 8'd7 || bus.err_pulse !== 1'b0) begin
      errors++; $display("FAIL stall_resume got exp=%0d pulse=%b want 7 0", bus.expected, bus.err_pulse);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturate();
    out_t o, e;
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'd100, k == 4);
      checks++;
      if (bus.err_pulse !== 1'b1 || bus.err_count !== want[k]) begin
        errors++;
        $display("FAIL sat[%0d] got pulse=%b cnt=%0d want 1 %0d", k, bus.err_pulse, bus.err_count, want[k]);
      end
      for (int i = 1; i < 5; i++) step(1'b0, 1'b1, 8'(100 + i), 1'b0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    out_t o, e;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(100 + i), 1'b0);
    checks++;
    if (bus.err_count !== 2'd2 || bus.locked !== 1'b1) begin
      errors++; $display("FAIL mid_pre got cnt=%0d locked=%b want 2 1", bus.err_count, bus.locked);
    end
    step(1'b1, 1'b1, 8'd50, 1'b0);
    checks++;
    if (sample() !== out_t'(0)) begin errors++; $display("FAIL mid_rst got %h want 0", sample()); end
    step(1'b0, 1'b1, 8'd7, 1'b0);
    checks++;
    if (bus.locked !== 1'b0 || bus.expected !== 8'd8 || bus.err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_seed got locked=%b exp=%0d pulse=%b want 0 8 0", bus.locked, bus.expected, bus.err_pulse);
    end
    for (int i = 8; i < 11; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_train got %b want 0", bus.locked); end
    step(1'b0, 1'b1, 8'd11, 1'b0);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL mid_relock got %b want 1", bus.locked); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_sb got %h want %h", o, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.count_in = '0;
    bus.err_clr = 1'b0;
    test_reset();
    test_lock();
    test_wrap();
    test_error_relock();
    test_stall();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
